// File: rtl/dma_pkg.sv
// dma_pkg: shared FSM state encoding and default address step for the DMA transfer controller
package dma_pkg;
  localparam int ADDR_STEP_DEF = 4;
  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR, WR_RESP, DONE} dma_state_t;
endpackage

// File: rtl/edge_detect_rise.sv
// edge_detect_rise: registered one-cycle pulse on each rising edge of d (ports: clk, rst, d, pulse)
module edge_detect_rise (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic pulse
);
  logic d_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      d_q <= 1'b0;
      pulse <= 1'b0;
    end else begin
      d_q <= d;
      pulse <= d & ~d_q;
    end
endmodule

// File: rtl/dma_xfer_ctrl.sv
// dma_xfer_ctrl: single-outstanding word-copy DMA over AXI4-Lite (ports: clk/rst, register-block src/dst/len/start, AXI ar/r/aw/w/b master channels, busy/done status)
module dma_xfer_ctrl
  import dma_pkg::*;
#(
  parameter int ADDR_STEP = ADDR_STEP_DEF,
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_src_addr,
  input  logic [31:0] i_dst_addr,
  input  logic [31:0] i_len,
  input  logic        i_ctrl_start,
  output logic [31:0] m_araddr,
  output logic        m_arvalid,
  input  logic        m_arready,
  input  logic [31:0] m_rdata,
  input  logic        m_rvalid,
  output logic        m_rready,
  output logic [31:0] m_awaddr,
  output logic        m_awvalid,
  input  logic        m_awready,
  output logic [31:0] m_wdata,
  output logic        m_wvalid,
  input  logic        m_wready,
  input  logic        m_bvalid,
  output logic        m_bready,
  output logic        o_busy,
  output logic        o_status_done
);
  dma_state_t state, next_state;
  logic start, go, idle_like, zero_len, aw_ok, w_ok, aw_done, w_done;
  logic [31:0] src_q, dst_q, buf_q;
  logic [CNT_W-1:0] rem_q;
  edge_detect_rise u_edge (.clk(clk), .rst(rst), .d(i_ctrl_start), .pulse(start));
  assign idle_like = state == IDLE || state == DONE;
  assign go = start && idle_like;
  assign zero_len = CNT_W'(i_len) == '0;
  assign aw_ok = aw_done || m_awready;
  assign w_ok = w_done || m_wready;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= next_state;
  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE: if (start) next_state = zero_len ? DONE : RD_ADDR;
      RD_ADDR: if (m_arready) next_state = RD_DATA;
      RD_DATA: if (m_rvalid) next_state = WR;
      WR: if (aw_ok && w_ok) next_state = WR_RESP;
      WR_RESP: if (m_bvalid) next_state = rem_q == CNT_W'(1) ? DONE : RD_ADDR;
      default: next_state = IDLE;
    endcase
  end
  always_comb begin
    m_arvalid = state == RD_ADDR;
    m_rready = state == RD_DATA;
    m_awvalid = state == WR && !aw_done;
    m_wvalid = state == WR && !w_done;
    m_bready = state == WR_RESP;
    o_busy = !idle_like;
    o_status_done = state == DONE;
    m_araddr = src_q;
    m_awaddr = dst_q;
    m_wdata = buf_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      src_q <= '0;
      dst_q <= '0;
      buf_q <= '0;
      rem_q <= '0;
      aw_done <= 1'b0;
      w_done <= 1'b0;
    end else begin
      if (go) begin
        src_q <= i_src_addr;
        dst_q <= i_dst_addr;
        rem_q <= CNT_W'(i_len);
      end
      if (state == RD_DATA && m_rvalid) buf_q <= m_rdata;
      aw_done <= state == WR && !(aw_ok && w_ok) && aw_ok;
      w_done <= state == WR && !(aw_ok && w_ok) && w_ok;
      if (state == WR_RESP && m_bvalid) begin
        src_q <= src_q + 32'(ADDR_STEP);
        dst_q <= dst_q + 32'(ADDR_STEP);
        rem_q <= rem_q - CNT_W'(1);
      end
    end
endmodule
